// File: rtl/multi_irq_ctrl.sv
// Interrupt controller for up to eight external lines: synchronizes each line,
// keeps per-line pending state (edge or level), and runs a non-nesting request/service handshake.
module multi_irq_ctrl #(
  parameter int          NIRQ = 8,
  parameter logic [7:0]  EDGE = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq_in,
  input  logic [NIRQ-1:0] im,
  input  logic            ie,
  input  logic            exl,
  input  logic            inta,
  input  logic            eret,
  input  logic            ipclr_we,
  input  logic [NIRQ-1:0] ipclr,
  output logic            intr,
  output logic [7:0]      imip,
  output logic [2:0]      irq_id,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  logic [NIRQ-1:0] s1_r;
  logic [NIRQ-1:0] s2_r;
  logic [NIRQ-1:0] s3_r;
  logic [NIRQ-1:0] pending_r;
  state_t          state_r;
  logic            intr_r;
  logic            busy_r;
  logic [2:0]      irq_id_r;
  logic [7:0]      imip_s;
  logic            req_ok_s;

  // Lowest set index wins, so line 0 has the highest priority.
  function automatic logic [2:0] lowest_index(input logic [7:0] v);
    logic [2:0] id;
    id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      id = v[i] ? 3'(i) : id;
    end
    return id;
  endfunction

  // Two synchronizer stages plus a history stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= '0;
      s2_r <= '0;
      s3_r <= '0;
    end else begin
      s1_r <= irq_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Pending bits: edge lines latch a rising edge (set beats clear), level lines follow s2.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= '0;
    end else begin
      for (int i = 0; i < NIRQ; i++) begin
        if (EDGE[i]) begin
          if (s2_r[i] && !s3_r[i]) begin
            pending_r[i] <= 1'b1;
          end else if (ipclr_we && ipclr[i]) begin
            pending_r[i] <= 1'b0;
          end else begin
            pending_r[i] <= pending_r[i];
          end
        end else begin
          pending_r[i] <= s2_r[i];
        end
      end
    end
  end

  // Masked pending vector, upper unused bits held at zero.
  always_comb begin
    imip_s               = 8'h00;
    imip_s[NIRQ-1:0]     = pending_r & im;
    req_ok_s             = (|imip_s) & ie & ~exl;
  end

  // Request/service FSM; intr and busy are registered alongside the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      intr_r   <= 1'b0;
      busy_r   <= 1'b0;
      irq_id_r <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_ok_s) begin
            state_r  <= REQ;
            intr_r   <= 1'b1;
            busy_r   <= 1'b1;
            irq_id_r <= lowest_index(imip_s);
          end else begin
            state_r  <= IDLE;
            intr_r   <= 1'b0;
            busy_r   <= 1'b0;
          end
        end
        REQ: begin
          // Acceptance takes precedence over withdrawal in the same cycle.
          if (inta) begin
            state_r <= SERV;
            intr_r  <= 1'b0;
            busy_r  <= 1'b1;
          end else if (!req_ok_s) begin
            state_r <= IDLE;
            intr_r  <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            state_r <= REQ;
            intr_r  <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        SERV: begin
          if (eret) begin
            state_r <= IDLE;
            intr_r  <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            state_r <= SERV;
            intr_r  <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          intr_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign intr   = intr_r;
  assign busy   = busy_r;
  assign irq_id = irq_id_r;
  assign imip   = imip_s;

endmodule
